// File: rtl/dmem_responder.sv
// dmem_responder: 512-byte little-endian data memory behind a rd/wr/ready port.
// Define DMEM_WAIT_STATES_EN to compile in the WAIT state and stall counter.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = (2 ** ADDR_W) / 4;

    if (DATA_W != 32 || WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_cfg
        $error("dmem_responder: unsupported DATA_W or WAIT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DMEM_WAIT_STATES_EN
        WAIT = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          f3_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q, wr_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                ready_q, err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef DMEM_WAIT_STATES_EN
    logic [3:0]          cnt_q, cnt_d;
`endif

    logic                accept, commit;
    logic                illegal, misal, both;
    logic [1:0]          lane;
    logic [ADDR_W-3:0]   idx;
    logic [3:0]          be;
    logic [DATA_W-1:0]   wlane, word, ld_val;
    logic [7:0]          ld_b;
    logic [15:0]         ld_h;

    assign accept = (state_q == IDLE) && (rd || wr);
    assign commit = (state_q == DONE);
    assign lane   = addr_q[1:0];
    assign idx    = addr_q[ADDR_W-1:2];
    assign both   = rd_q && wr_q;

    // Next-state logic and stall counter.
    always_comb begin
        state_d = state_q;
`ifdef DMEM_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rd || wr) begin
`ifdef DMEM_WAIT_STATES_EN
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DMEM_WAIT_STATES_EN
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection, alignment check and load extension for the latched access.
    always_comb begin
        illegal = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
        misal   = 1'b0;
        be      = 4'b0000;
        wlane   = wdata_q;
        word    = mem_q[idx];
        ld_b    = word[{lane, 3'b000} +: 8];
        ld_h    = addr_q[1] ? word[31:16] : word[15:0];
        ld_val  = '0;
        unique case (f3_q[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wlane  = {4{wdata_q[7:0]}};
                ld_val = {{24{ld_b[7] & ~f3_q[2]}}, ld_b};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane  = {2{wdata_q[15:0]}};
                ld_val = {{16{ld_h[15] & ~f3_q[2]}}, ld_h};
                misal  = addr_q[0];
            end
            2'b10: begin
                be     = 4'b1111;
                wlane  = wdata_q;
                ld_val = word;
                misal  = |lane;
            end
            default: ;
        endcase
    end

    // State register and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef DMEM_WAIT_STATES_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef DMEM_WAIT_STATES_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Capture the request when it is accepted from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr;
            f3_q    <= funct3;
            wdata_q <= wr_data;
            rd_q    <= rd;
            wr_q    <= wr;
        end
    end

    // Completion pulse, error flag and held load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= commit;
            err_q   <= commit && (illegal || both || misal);
            if (commit && rd_q) begin
                rd_data_q <= (wr_q || illegal) ? '0 : ld_val;
            end
        end
    end

    // Byte-lane store on the completing edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !illegal) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized load/store traffic against a byte-array model.
// Latency expectation follows DMEM_WAIT_STATES_EN when it is defined.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int WC = 3;
`ifdef DMEM_WAIT_STATES_EN
    localparam int LAT = 1 + WC;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [8:0]  addr = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ready;
    logic        err;

    dmem_responder #(
        .DATA_W(32),
        .ADDR_W(9),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd(rd),
        .wr(wr),
        .addr(addr),
        .funct3(funct3),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .ready(ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte array plus the one outstanding expected completion.
    logic [7:0]  mb [512];
    logic [31:0] model_rd = '0;
    bit          pend = 1'b0;
    int          exp_cyc = 0;
    logic [31:0] exp_rd = '0;
    logic        exp_err = 1'b0;
    bit          pw_en = 1'b0;
    int          pw_addr = 0;
    int          pw_n = 0;
    logic [31:0] pw_data = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic predict(input bit r, input bit w, input int a,
                           input logic [2:0] f, input logic [31:0] d);
        int n;
        int al;
        bit bad;
        logic [31:0] v;
        bad = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
        n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        al = a - (a % n);
        exp_err = bad || (r && w) || (al != a);
        pw_en = w && !bad;
        pw_addr = al;
        pw_n = n;
        pw_data = d;
        if (r && !w && !bad) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[al+i]) << (8*i));
            if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_rd = v;
        end else if (r) begin
            exp_rd = '0;
        end else begin
            exp_rd = model_rd;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (pend && cyc == exp_cyc) begin
                check("ready", 32'(ready), 32'd1);
                check("err", 32'(err), 32'(exp_err));
                check("rd_data", rd_data, exp_rd);
                model_rd = exp_rd;
                if (pw_en)
                    for (int i = 0; i < pw_n; i++) mb[pw_addr+i] = pw_data[8*i +: 8];
                pend = 1'b0;
            end else begin
                check("ready_idle", 32'(ready), 32'd0);
                check("err_idle", 32'(err), 32'd0);
                check("rd_hold", rd_data, model_rd);
            end
        end
    end

    // Issue one access at a negedge, hold it until ready, then drop it.
    task automatic access(input bit r, input bit w, input logic [8:0] a,
                          input logic [2:0] f, input logic [31:0] d,
                          output logic [31:0] grd, output logic ge);
        int s;
        int n;
        rd = r;
        wr = w;
        addr = a;
        funct3 = f;
        wr_data = d;
        @(negedge clk);
        s = cyc;
        predict(r, w, int'(a), f, d);
        exp_cyc = s + LAT;
        pend = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            addr = 9'($urandom);
            funct3 = 3'($urandom);
            wr_data = $urandom;
            @(negedge clk);
            n++;
        end
        grd = rd_data;
        ge = err;
        rd = 1'b0;
        wr = 1'b0;
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        else check("latency", 32'(cyc - s), 32'(LAT));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        logic        e;
        logic [2:0]  legal [5];
        int          op;
        logic [2:0]  f;
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b101;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        for (int i = 0; i < 128; i++) begin
            access(1'b0, 1'b1, 9'(i*4), 3'b010, $urandom, g, e);
        end

        access(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, g, e);
        check("sw_err", 32'(e), 32'd0);
        access(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, g, e);
        check("lw_word", g, 32'hDEADBEEF);
        check("lw_err", 32'(e), 32'd0);

        access(1'b0, 1'b1, 9'h010, 3'b010, 32'h11223344, g, e);
        access(1'b0, 1'b1, 9'h013, 3'b000, 32'h00000080, g, e);
        access(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, g, e);
        check("lw_after_sb", g, 32'h80223344);
        access(1'b1, 1'b0, 9'h013, 3'b000, 32'h0, g, e);
        check("lb_sext", g, 32'hFFFFFF80);
        access(1'b1, 1'b0, 9'h013, 3'b100, 32'h0, g, e);
        check("lbu_zext", g, 32'h00000080);

        access(1'b0, 1'b1, 9'h020, 3'b010, 32'h0, g, e);
        access(1'b0, 1'b1, 9'h022, 3'b001, 32'h00008001, g, e);
        access(1'b1, 1'b0, 9'h022, 3'b001, 32'h0, g, e);
        check("lh_sext", g, 32'hFFFF8001);
        check("lh_err", 32'(e), 32'd0);
        access(1'b1, 1'b0, 9'h021, 3'b010, 32'h0, g, e);
        check("lw_misal_data", g, 32'h80010000);
        check("lw_misal_err", 32'(e), 32'd1);

        access(1'b1, 1'b0, 9'h010, 3'b111, 32'h0, g, e);
        check("illegal_rd", g, 32'd0);
        check("illegal_err", 32'(e), 32'd1);
        access(1'b1, 1'b1, 9'h030, 3'b010, 32'h12345678, g, e);
        check("both_rd", g, 32'd0);
        check("both_err", 32'(e), 32'd1);
        access(1'b1, 1'b0, 9'h030, 3'b010, 32'h0, g, e);
        check("lw_after_both", g, 32'h12345678);

        access(1'b0, 1'b1, 9'h040, 3'b010, 32'h0, g, e);
        access(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, g, e);
        rd = 1'b0;
        wr = 1'b1;
        addr = 9'h040;
        funct3 = 3'b010;
        wr_data = 32'hAAAA5555;
        @(negedge clk);
        reset = 1'b1;
        pend = 1'b0;
        wr = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        model_rd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        access(1'b1, 1'b0, 9'h040, 3'b010, 32'h0, g, e);
        check("lw_after_abort", g, 32'h00000000);

        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) f = 3'($urandom);
            else f = legal[$urandom_range(0, 4)];
            access(op < 5 || op == 9, op >= 5, 9'($urandom), f, $urandom, g, e);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
